fetch_stage: RTL and testbench

- Fetch stage of the 5-stage RV32I pipeline, directly upstream of the hazard/stall unit.
- Generates the PC and issues requests to instruction memory over a valid/ready handshake; at most one request is outstanding.
- Holds the fetched instruction as inst_f, which feeds the stall unit, and advances it into the F/D pipeline register.
- Consumes the stall unit's registered stall, plus redirects from execute (taken branch, jal, jalr).

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage_fd_reg.sv | 36 +++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared RV32I pipeline definitions: bubble instruction, major opcodes and
// the fetch FSM state encoding.
package rv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory valid/ready request channel plus response strobe.
// The fetch stage is the master; the memory is the slave.
interface fetch_stage_if;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_stage_fd_reg.sv
// Pipeline register between two stages with bubble/load/hold controls.
// Bubble beats load; with neither load nor hold the register bubbles.
module fd_reg
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP = rv_pkg::NOP_INST
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hold,
  input  logic        bubble,
  input  logic        load,
  input  logic [31:0] next_inst,
  input  logic [31:0] next_pc,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        valid
);

  always_ff @(posedge clock) begin
    if (reset || bubble) begin
      inst  <= NOP;
      pc    <= 32'd0;
      valid <= 1'b0;
    end else if (load) begin
      inst  <= next_inst;
      pc    <= next_pc;
      valid <= 1'b1;
    end else if (!hold) begin
      inst  <= NOP;
      pc    <= 32'd0;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC generation, single-outstanding instruction fetch,
// the F holding slot and the F/D pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter logic [31:0] NOP_INST = rv_pkg::NOP_INST
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  fetch_stage_if.master imem,
  output logic [31:0]  inst_f,
  output logic [31:0]  pc_f,
  output logic [31:0]  inst_d,
  output logic [31:0]  pc_d,
  output logic         valid_d
);

  import rv_pkg::*;

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         f_valid;
  logic         f_drain;
  logic         req_fire;
  logic         rsp_take;

  // Requests only go out when F is empty or emptying this cycle, so a
  // response can never collide with a held instruction.
  always_comb begin
    f_drain             = f_valid && !stall && !redirect_valid;
    imem.imem_req_valid = (state == S_REQ) && (!f_valid || f_drain) && !reset;
    imem.imem_req_addr  = pc;
    req_fire            = imem.imem_req_valid && imem.imem_req_ready;
    rsp_take            = (state == S_WAIT) && imem.imem_rsp_valid && !redirect_valid;
    state_next          = state;
    case (state)
      S_REQ: begin
        if (req_fire)
          state_next = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid)
          state_next = S_REQ;
        else if (redirect_valid)
          state_next = S_DROP;
      end
      S_DROP: begin
        if (imem.imem_rsp_valid)
          state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= S_REQ;
    else
      state <= state_next;
  end

  // A redirect overrides both the sequential PC and any arriving response.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc      <= RESET_PC;
      req_pc  <= RESET_PC;
      f_valid <= 1'b0;
      inst_f  <= NOP_INST;
      pc_f    <= 32'd0;
    end else begin
      if (req_fire)
        req_pc <= pc;
      if (redirect_valid)
        pc <= redirect_pc & ~32'd3;
      else if (req_fire)
        pc <= pc + 32'd4;
      if (redirect_valid) begin
        f_valid <= 1'b0;
        inst_f  <= NOP_INST;
      end else if (rsp_take) begin
        inst_f  <= imem.imem_rsp_data;
        pc_f    <= req_pc;
        f_valid <= 1'b1;
      end else if (!stall && f_valid) begin
        f_valid <= 1'b0;
        inst_f  <= NOP_INST;
      end
    end
  end

  fd_reg #(
    .NOP(NOP_INST)
  ) u_fd_reg (
    .clock     (clock),
    .reset     (reset),
    .hold      (1'b0),
    .bubble    (redirect_valid || stall),
    .load      (f_valid),
    .next_inst (inst_f),
    .next_pc   (pc_f),
    .inst      (inst_d),
    .pc        (pc_d),
    .valid     (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk-through of the key scenarios, then
// random traffic against a program-order scoreboard and a memory model.
module tb_fetch_stage;

  import rv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst_f;
  logic [31:0] pc_f;
  logic [31:0] inst_d;
  logic [31:0] pc_d;
  logic        valid_d;

  fetch_stage_if imem ();

  fetch_stage #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP_INST)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .inst_f         (inst_f),
    .pc_f           (pc_f),
    .inst_d         (inst_d),
    .pc_d           (pc_d),
    .valid_d        (valid_d)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  logic        pending = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          pend_cnt = 0;
  logic [31:0] expected_pc = RESET_PC;
  int          delivered = 0;
  logic        last_req_valid;
  logic [31:0] last_req_addr;

  // Memory image: two fixed words at the reset vector, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC)
      return 32'h0000_0093;
    if (a == RESET_PC + 32'd4)
      return 32'h00a5_0863;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, let the memory
  // model answer, then check the F/D result on the next falling edge
  // against the expected sequential program order.
  task automatic applyStimulus(input logic rst, input logic st, input logic rd,
                               input logic [31:0] rpc, input logic rdy,
                               input int lat);
    logic fire;
    reset               = rst;
    stall               = st;
    redirect_valid      = rd;
    redirect_pc         = rpc;
    imem.imem_req_ready = rdy;
    if (pending && pend_cnt == 0) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = mem_word(pend_addr);
    end else begin
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = $urandom;
      if (pending)
        pend_cnt--;
    end
    #1;
    last_req_valid = imem.imem_req_valid;
    last_req_addr  = imem.imem_req_addr;
    fire = (last_req_valid === 1'b1) && rdy;
    if (fire)
      checkOutput("req_align", {30'd0, last_req_addr[1:0]}, 32'd0);
    @(posedge clock);
    if (imem.imem_rsp_valid)
      pending = 1'b0;
    if (rst) begin
      pending = 1'b0;
    end else if (fire) begin
      checkOutput("one_outstanding", 32'(pending), 32'd0);
      pending   = 1'b1;
      pend_addr = last_req_addr;
      pend_cnt  = lat - 1;
    end
    @(negedge clock);
    if (rst) begin
      expected_pc = RESET_PC;
      checkOutput("rst_valid_d", 32'(valid_d), 32'd0);
    end else begin
      if (rd || st)
        checkOutput("bubble_d", 32'(valid_d), 32'd0);
      if (valid_d === 1'b1) begin
        checkOutput("order_pc_d", pc_d, expected_pc);
        checkOutput("order_inst_d", inst_d, mem_word(pc_d));
        expected_pc = expected_pc + 32'd4;
        delivered++;
      end
      if (rd)
        expected_pc = rpc & ~32'd3;
    end
  endtask

  logic        r_rst;
  logic        r_st;
  logic        r_rd;
  logic        r_rdy;
  logic [31:0] r_rpc;
  int          r_lat;

  initial begin
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'd0;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1);
    checkOutput("rst_inst_f", inst_f, NOP_INST);
    checkOutput("rst_pc_f", pc_f, 32'd0);
    checkOutput("rst_inst_d", inst_d, NOP_INST);
    checkOutput("rst_pc_d", pc_d, 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
    checkOutput("first_req_valid", 32'(last_req_valid), 32'd1);
    checkOutput("first_req_addr", last_req_addr, RESET_PC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
    checkOutput("wait_no_req", 32'(last_req_valid), 32'd0);
    checkOutput("first_inst_f", inst_f, 32'h0000_0093);
    checkOutput("first_pc_f", pc_f, RESET_PC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
    checkOutput("second_req_addr", last_req_addr, RESET_PC + 32'd4);
    checkOutput("first_valid_d", 32'(valid_d), 32'd1);
    checkOutput("first_inst_d", inst_d, 32'h0000_0093);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
    checkOutput("beq_inst_f", inst_f, 32'h00a5_0863);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1);
      checkOutput("stall_no_req", 32'(last_req_valid), 32'd0);
      checkOutput("stall_inst_f", inst_f, 32'h00a5_0863);
      checkOutput("stall_pc_f", pc_f, RESET_PC + 32'd4);
      checkOutput("stall_valid_d", 32'(valid_d), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 3);
    checkOutput("unstall_valid_d", 32'(valid_d), 32'd1);
    checkOutput("unstall_inst_d", inst_d, 32'h00a5_0863);
    checkOutput("unstall_req_addr", last_req_addr, RESET_PC + 32'd8);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0100_0203, 1'b1, 1);
    checkOutput("redir_valid_d", 32'(valid_d), 32'd0);
    checkOutput("redir_inst_f", inst_f, NOP_INST);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
    checkOutput("drop_no_req", 32'(last_req_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
    checkOutput("drop_no_req2", 32'(last_req_valid), 32'd0);
    checkOutput("drop_inst_f", inst_f, NOP_INST);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
    checkOutput("redir_req_valid", 32'(last_req_valid), 32'd1);
    checkOutput("redir_req_addr", last_req_addr, 32'h0100_0200);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
    checkOutput("target_inst_f", inst_f, mem_word(32'h0100_0200));

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0100_0400, 1'b1, 1);
    checkOutput("rs_no_req", 32'(last_req_valid), 32'd0);
    checkOutput("rs_valid_d", 32'(valid_d), 32'd0);
    checkOutput("rs_inst_f", inst_f, NOP_INST);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1);
      checkOutput("busy_req_valid", 32'(last_req_valid), 32'd1);
      checkOutput("busy_req_addr", last_req_addr, 32'h0100_0400);
      checkOutput("busy_valid_d", 32'(valid_d), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 2);
    checkOutput("busy_accept_addr", last_req_addr, 32'h0100_0400);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1);
    checkOutput("midrst_inst_f", inst_f, NOP_INST);
    checkOutput("midrst_pc_f", pc_f, 32'd0);
    checkOutput("midrst_inst_d", inst_d, NOP_INST);
    checkOutput("midrst_pc_d", pc_d, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1);
    checkOutput("midrst_req_valid", 32'(last_req_valid), 32'd1);
    checkOutput("midrst_req_addr", last_req_addr, RESET_PC);

    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_rd  = ($urandom_range(0, 11) == 0);
      r_rdy = ($urandom_range(0, 9) < 7);
      r_rpc = RESET_PC + 32'($urandom_range(0, 4095));
      r_lat = $urandom_range(1, 3);
      applyStimulus(r_rst, r_st, r_rd, r_rpc, r_rdy, r_lat);
    end
    checkOutput("delivered_enough", (delivered > 200) ? 32'd1 : 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
